// File: rtl/riscv_pipe_pkg.sv
// Shared encodings, control bundle and pipeline-register layouts for riscv_pipe_cpu.
// The mul decode is present only when RISCV_PIPE_MUL_EN is defined.
package riscv_pipe_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
`ifdef RISCV_PIPE_MUL_EN
  localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SLL,
    ALU_SRA,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
  } ctrl_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        inst;
  } if_id_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    alu_op_e            alu_op;
    logic [RV_XLEN-1:0] rs1_val;
    logic [RV_XLEN-1:0] rs2_val;
    logic [RV_XLEN-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
  } id_ex_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic [RV_XLEN-1:0] alu_res;
    logic [RV_XLEN-1:0] store_data;
    logic [4:0]         rd;
  } ex_mem_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic [RV_XLEN-1:0] alu_res;
    logic [RV_XLEN-1:0] mem_data;
    logic [4:0]         rd;
  } mem_wb_t;

  // Unrecognised encodings fall out with every control bit low, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    c   = '0;
    case (opc)
      OPC_R: begin
        if (f7 == F7_BASE) begin
          c.reg_write = 1'b1;
          case (f3)
            F3_ADD:  c.alu_op = ALU_ADD;
            F3_SLL:  c.alu_op = ALU_SLL;
            F3_XOR:  c.alu_op = ALU_XOR;
            F3_AND:  c.alu_op = ALU_AND;
            default: c.reg_write = 1'b0;
          endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD) begin
          c.reg_write = 1'b1;
          c.alu_op    = ALU_SUB;
        end
`ifdef RISCV_PIPE_MUL_EN
        else if (f7 == F7_MUL && f3 == F3_ADD) begin
          c.reg_write = 1'b1;
          c.alu_op    = ALU_MUL;
        end
`endif
      end
      OPC_I: begin
        if (f3 == F3_ADD) begin
          c.reg_write = 1'b1;
          c.alu_src   = 1'b1;
          c.alu_op    = ALU_ADD;
        end else if (f3 == F3_SRA) begin
          c.reg_write = 1'b1;
          c.alu_src   = 1'b1;
          c.alu_op    = ALU_SRA;
        end
      end
      OPC_LW: begin
        if (f3 == F3_LW) begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.mem_read   = 1'b1;
          c.alu_src    = 1'b1;
        end
      end
      OPC_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_BEQ: c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Branch immediate is returned in half-word units; the caller shifts it.
  function automatic logic [RV_XLEN-1:0] gen_imm(input logic [31:0] inst);
    logic [RV_XLEN-1:0] imm;
    case (inst[6:0])
      OPC_SW:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BEQ: imm = {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_pipe_hazard_fwd.sv
// Load-use stall detector and EX operand forwarding selects for riscv_pipe_cpu.
// Purely combinational; EX/MEM results take priority over MEM/WB.
module riscv_pipe_hazard_fwd
  import riscv_pipe_pkg::*;
(
  input  logic       id_ex_mem_read_i,
  input  logic [4:0] id_ex_rd_i,
  input  logic [4:0] id_ex_rs1_i,
  input  logic [4:0] id_ex_rs2_i,
  input  logic [4:0] if_id_rs1_i,
  input  logic [4:0] if_id_rs2_i,
  input  logic       ex_mem_reg_write_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       mem_wb_reg_write_i,
  input  logic [4:0] mem_wb_rd_i,
  output logic       stall_o,
  output logic       pc_write_o,
  output logic       if_id_write_o,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  logic exm_ok, mwb_ok;

  assign exm_ok = ex_mem_reg_write_i && (ex_mem_rd_i != 5'd0);
  assign mwb_ok = mem_wb_reg_write_i && (mem_wb_rd_i != 5'd0);

  always_comb begin
    stall_o = id_ex_mem_read_i &&
              ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));
    pc_write_o    = !stall_o;
    if_id_write_o = !stall_o;

    fwd_a_o = FWD_NONE;
    if (exm_ok && ex_mem_rd_i == id_ex_rs1_i)      fwd_a_o = FWD_EXMEM;
    else if (mwb_ok && mem_wb_rd_i == id_ex_rs1_i) fwd_a_o = FWD_MEMWB;

    fwd_b_o = FWD_NONE;
    if (exm_ok && ex_mem_rd_i == id_ex_rs2_i)      fwd_b_o = FWD_EXMEM;
    else if (mwb_ok && mem_wb_rd_i == id_ex_rs2_i) fwd_b_o = FWD_MEMWB;
  end

endmodule

// File: rtl/riscv_pipe_cpu.sv
// riscv_pipe_cpu: 5-stage in-order RV32 subset core (IF, ID, EX, MEM, WB).
// Define RISCV_PIPE_MUL_EN to decode mul and build the EX multiplier.
module riscv_pipe_cpu
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 32,
  parameter int unsigned XLEN       = RV_XLEN,
  parameter logic [31:0] IMEM_INIT [IMEM_WORDS] = '{default: 32'h0}
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  id_ex_t          id_ex_q, id_ex_d;
  ex_mem_t         ex_mem_q, ex_mem_d;
  mem_wb_t         mem_wb_q, mem_wb_d;

  logic [XLEN-1:0] rf_q   [32];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS];

  logic     stall, flush, pc_write, if_id_write, br_taken;
  fwd_sel_e fwd_a, fwd_b;

  logic [31:0]            inst_if;
  ctrl_t                  ctrl_id;
  logic [4:0]             rs1_id, rs2_id, rd_id;
  logic [XLEN-1:0]        rs1_val_id, rs2_val_id, imm_id, br_target;
  logic signed [XLEN-1:0] op_a_ex, rs2_fwd_ex, op_b_ex, alu_res_ex;
  logic [XLEN-1:0]        mem_rdata, wb_data;

  function automatic logic signed [XLEN-1:0] alu(input alu_op_e op,
                                                 input logic signed [XLEN-1:0] a,
                                                 input logic signed [XLEN-1:0] b);
    logic signed [XLEN-1:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRA: r = a >>> b[4:0];
`ifdef RISCV_PIPE_MUL_EN
      ALU_MUL: r = a * b;
`endif
      default: r = a + b;
    endcase
    return r;
  endfunction

  // ---- IF ----
  assign inst_if = IMEM_INIT[pc_q[9:2]];

  // ---- ID ----
  assign rs1_id  = if_id_q.inst[19:15];
  assign rs2_id  = if_id_q.inst[24:20];
  assign rd_id   = if_id_q.inst[11:7];
  assign ctrl_id = decode(if_id_q.inst);
  assign imm_id  = gen_imm(if_id_q.inst);

  // WB data is bypassed so a same-cycle write is visible to the ID read.
  assign rs1_val_id = (rs1_id == 5'd0) ? '0 :
                      (mem_wb_q.reg_write && mem_wb_q.rd == rs1_id) ? wb_data : rf_q[rs1_id];
  assign rs2_val_id = (rs2_id == 5'd0) ? '0 :
                      (mem_wb_q.reg_write && mem_wb_q.rd == rs2_id) ? wb_data : rf_q[rs2_id];

  assign br_target = if_id_q.pc + (imm_id << 1);
  assign br_taken  = ctrl_id.branch && (rs1_val_id == rs2_val_id);
  assign flush     = br_taken && pc_write && start_i;

  riscv_pipe_hazard_fwd u_hazard_fwd (
    .id_ex_mem_read_i   (id_ex_q.mem_read),
    .id_ex_rd_i         (id_ex_q.rd),
    .id_ex_rs1_i        (id_ex_q.rs1),
    .id_ex_rs2_i        (id_ex_q.rs2),
    .if_id_rs1_i        (rs1_id),
    .if_id_rs2_i        (rs2_id),
    .ex_mem_reg_write_i (ex_mem_q.reg_write),
    .ex_mem_rd_i        (ex_mem_q.rd),
    .mem_wb_reg_write_i (mem_wb_q.reg_write),
    .mem_wb_rd_i        (mem_wb_q.rd),
    .stall_o            (stall),
    .pc_write_o         (pc_write),
    .if_id_write_o      (if_id_write),
    .fwd_a_o            (fwd_a),
    .fwd_b_o            (fwd_b)
  );

  // With start_i low the front end freezes and ID issues bubbles, so nothing is lost or replayed.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (pc_write && start_i) pc_d = br_taken ? br_target : pc_q + XLEN'(4);
    if (if_id_write && start_i) begin
      if (flush) begin
        if_id_d = '0;
      end else begin
        if_id_d.pc   = pc_q;
        if_id_d.inst = inst_if;
      end
    end

    id_ex_d = '0;
    if (!stall && start_i) begin
      id_ex_d.reg_write  = ctrl_id.reg_write;
      id_ex_d.mem_to_reg = ctrl_id.mem_to_reg;
      id_ex_d.mem_read   = ctrl_id.mem_read;
      id_ex_d.mem_write  = ctrl_id.mem_write;
      id_ex_d.alu_src    = ctrl_id.alu_src;
      id_ex_d.alu_op     = ctrl_id.alu_op;
      id_ex_d.rs1_val    = rs1_val_id;
      id_ex_d.rs2_val    = rs2_val_id;
      id_ex_d.imm        = imm_id;
      id_ex_d.rs1        = rs1_id;
      id_ex_d.rs2        = rs2_id;
      id_ex_d.rd         = rd_id;
    end
  end

  // ---- EX ----
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: op_a_ex = ex_mem_q.alu_res;
      FWD_MEMWB: op_a_ex = wb_data;
      default:   op_a_ex = id_ex_q.rs1_val;
    endcase
    case (fwd_b)
      FWD_EXMEM: rs2_fwd_ex = ex_mem_q.alu_res;
      FWD_MEMWB: rs2_fwd_ex = wb_data;
      default:   rs2_fwd_ex = id_ex_q.rs2_val;
    endcase
    op_b_ex    = id_ex_q.alu_src ? id_ex_q.imm : rs2_fwd_ex;
    alu_res_ex = alu(id_ex_q.alu_op, op_a_ex, op_b_ex);

    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.alu_res    = alu_res_ex;
    ex_mem_d.store_data = rs2_fwd_ex;
    ex_mem_d.rd         = id_ex_q.rd;
  end

  // ---- MEM ----
  assign mem_rdata = dmem_q[ex_mem_q.alu_res[6:2]];

  always_comb begin
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.alu_res    = ex_mem_q.alu_res;
    mem_wb_d.mem_data   = mem_rdata;
    mem_wb_d.rd         = ex_mem_q.rd;
  end

  // ---- WB ----
  assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.mem_data : mem_wb_q.alu_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Storage arrays are never cleared; writes are only suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_wb_q.reg_write && mem_wb_q.rd != 5'd0) rf_q[mem_wb_q.rd] <= wb_data;
    if (!rst_i && ex_mem_q.mem_write) dmem_q[ex_mem_q.alu_res[6:2]] <= ex_mem_q.store_data;
  end

endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// Directed bench for riscv_pipe_cpu: one hand-assembled program in the ROM, results
// checked against hand-computed register, memory, stall, flush and PC values.
module tb_riscv_pipe_cpu;

  localparam logic [31:0] PROG [256] = '{
    0:  32'h00500093,  // addi x1,x0,5
    1:  32'h00700113,  // addi x2,x0,7
    2:  32'h002081B3,  // add  x3,x1,x2
    3:  32'h40118233,  // sub  x4,x3,x1
    4:  32'h00302223,  // sw   x3,4(x0)
    5:  32'h00402283,  // lw   x5,4(x0)
    6:  32'h00128313,  // addi x6,x5,1
    7:  32'hFF000413,  // addi x8,x0,-16
    8:  32'h40245493,  // srai x9,x8,2
    9:  32'h00100513,  // addi x10,x0,1
    10: 32'h00A515B3,  // sll  x11,x10,x10
    11: 32'h06300013,  // addi x0,x0,99
    12: 32'h000007B3,  // add  x15,x0,x0
    13: 32'h00300093,  // addi x1,x0,3
    14: 32'h00300113,  // addi x2,x0,3
    15: 32'h00000393,  // addi x7,x0,0
    17: 32'h00208463,  // beq  x1,x2,+8 (taken)
    18: 32'h00900393,  // addi x7,x0,9 (flushed)
    19: 32'h00100813,  // addi x16,x0,1
    20: 32'h00400113,  // addi x2,x0,4
    23: 32'h00208463,  // beq  x1,x2,+8 (not taken)
    24: 32'h00900913,  // addi x18,x0,9
    25: 32'h00600093,  // addi x1,x0,6
    26: 32'hFFD00113,  // addi x2,x0,-3
    27: 32'h04D00613,  // addi x12,x0,77
    28: 32'h02208633,  // mul  x12,x1,x2
    default: 32'h00000000
  };

`ifdef RISCV_PIPE_MUL_EN
  localparam logic [31:0] EXP_X12 = 32'hFFFFFFEE;
`else
  localparam logic [31:0] EXP_X12 = 32'h0000004D;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_stall = 0;
  int n_flush = 0;
  logic [31:0] stall_pc = '0, pc_after_stall = '0, pc_after_flush = '0;
  logic stall_d = 1'b0, flush_d = 1'b0;

  riscv_pipe_cpu #(.IMEM_INIT(PROG)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (stall_d) pc_after_stall = dut.pc_q;
        if (flush_d) pc_after_flush = dut.pc_q;
        if (dut.stall) begin
          n_stall++;
          stall_pc = dut.pc_q;
        end
        if (dut.flush) n_flush++;
        stall_d = dut.stall;
        flush_d = dut.flush;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", dut.pc_q, 32'h0);
    chk("reset_if_id", 32'(dut.if_id_q == '0), 32'd1);
    chk("reset_id_ex", 32'(dut.id_ex_q == '0), 32'd1);
    chk("reset_ex_mem", 32'(dut.ex_mem_q == '0), 32'd1);
    chk("reset_mem_wb", 32'(dut.mem_wb_q == '0), 32'd1);
    chk("reset_stall", 32'(dut.stall), 32'd0);
    chk("reset_pc_write", 32'(dut.pc_write), 32'd1);
    chk("reset_if_id_write", 32'(dut.if_id_write), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_pc_%0d", i), dut.pc_q, 32'h0);
    end

    @(negedge clk);
    start = 1'b1;
    repeat (45) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    chk("x3_add_fwd", dut.rf_q[3], 32'd12);
    chk("x4_sub_fwd", dut.rf_q[4], 32'd7);
    chk("dmem1_sw", dut.dmem_q[1], 32'd12);
    chk("x5_lw", dut.rf_q[5], 32'd12);
    chk("x6_load_use", dut.rf_q[6], 32'd13);
    chk("stall_count", 32'(n_stall), 32'd1);
    chk("stall_pc", stall_pc, 32'd28);
    chk("pc_held_in_stall", pc_after_stall, 32'd28);
    chk("x9_srai", dut.rf_q[9], 32'hFFFFFFFC);
    chk("x11_sll", dut.rf_q[11], 32'd2);
    chk("x15_x0_no_fwd", dut.rf_q[15], 32'd0);
    chk("x7_beq_flushed", dut.rf_q[7], 32'd0);
    chk("x16_beq_target", dut.rf_q[16], 32'd1);
    chk("flush_count", 32'(n_flush), 32'd1);
    chk("pc_after_flush", pc_after_flush, 32'd76);
    chk("x18_beq_not_taken", dut.rf_q[18], 32'd9);
    chk("x1_final", dut.rf_q[1], 32'd6);
    chk("x2_final", dut.rf_q[2], 32'hFFFFFFFD);
    chk("x12_mul", dut.rf_q[12], EXP_X12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_cpu.md
Name: riscv_pipe_cpu

Overview:
- 5-stage in-order RV32 subset pipeline: IF, ID, EX, MEM, WB. Top-level processor block of the design.
- Contains PC, 256-word instruction ROM, 32x32 register file, 32-word data RAM, and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
- Full EX-stage forwarding. Load-use stall detection. beq resolved in ID with a 1-instruction flush.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; word address = PC[9:2].
- DMEM_WORDS, 32, data memory depth in 32-bit words; word address = ALU result[6:2].
- XLEN, 32, datapath width.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  run enable; PC advances only while high.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high.
- Reset: the following clear to 0 at the clock edge with rst_i=1:
  - PC.
  - All pipeline registers and their control bits.
  - Hazard outputs: stall=0, PCWrite=1, IF_ID write=1.
  - Register file and memories are NOT cleared by reset; the loader/bench initialises them.
- PC: next PC selection, in priority order:
  - rst_i → 0.
  - start_i=0 or stall → hold.
  - Branch taken in ID → branch target.
  - Otherwise PC+4.
- Instruction set. Encodings: opcode 0110011 = R-type, 0010011 = I-type ALU.
  - and: funct3 111.
  - xor: funct3 100.
  - sll: funct3 001.
  - add: funct3 000, funct7 0000000.
  - sub: funct3 000, funct7 0100000.
  - mul: funct3 000, funct7 0000001; low 32 bits of the product.
  - addi: opcode 0010011, funct3 000.
  - srai: opcode 0010011, funct3 101, shamt = imm[4:0]; arithmetic shift.
  - lw: opcode 0000011, funct3 010.
  - sw: opcode 0100011.
  - beq: opcode 1100011.
  - Any other encoding (including all-zero) is a NOP: no register write, no memory write.
- Immediates:
  - I-type: imm[11:0] = inst[31:20].
  - S-type: imm = {inst[31:25], inst[11:7]}.
  - B-type: imm = {inst[31], inst[7], inst[30:25], inst[11:8]}; target = ID PC + (sext(imm) << 1).
  - All immediates are sign-extended to 32 bits.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Written at the clock edge from WB.
  - Same-cycle WB write and ID read of the same register returns the new value (internal bypass).
- Forwarding, for each EX source operand:
  - EX/MEM RegWrite, rd≠0 and rd==rs → use the EX/MEM ALU result.
  - Else MEM/WB RegWrite, rd≠0 and rd==rs → use the WB data.
  - EX/MEM has priority over MEM/WB.
  - The forwarded rs2 value is also the sw store data.
- Load-use hazard:
  - Condition: ID/EX MemRead and ID/EX rd equals IF/ID rs1 or rs2.
  - Action: hold PC, hold IF/ID, insert a bubble into ID/EX (all control bits 0) for 1 cycle.
- beq:
  - Compared in ID using register-file values. No forwarding into ID.
  - Software guarantees beq operands are not produced by the 2 preceding instructions.
  - Taken: PC ← target and IF/ID is flushed to instruction 0 (1 flush).
  - Not taken: no penalty.
  - Stall and flush in the same cycle: stall wins; the branch re-evaluates the next cycle.
- Data memory: write on clock edge when MEM MemWrite. Read combinational.
- Latency: an instruction fetched at cycle n writes back at the edge ending cycle n+4.
- Observability: expose internal signals stall (load-use) and flush (branch taken), one cycle wide each.

Optional Feature:
- Macro: RISCV_PIPE_MUL_EN.
- Defined: mul is decoded and executed by a combinational 32x32 multiplier (low word) in EX.
- Undefined: funct7 0000001 R-type is a NOP and no multiplier is synthesised.

Decomposition:
- Package riscv_pipe_pkg holds:
  - Opcode, funct3 and funct7 constants.
  - ALU-operation enum.
  - Typedef structs for each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp, Branch).
- Sub-module: riscv_pipe_hazard_fwd. It contains the load-use detector and forwarding mux selects and is purely combinational.

Test Plan:
1. Reset → PC=0, all pipeline control bits 0. start_i=0 for 3 cycles → PC holds 0.
2. addi x1,x0,5 ; addi x2,x0,7 ; add x3,x1,x2 ; sub x4,x3,x1 (back-to-back) → x3=12, x4=7 via forwarding, no stalls.
3. sw x3,4(x0) ; lw x5,4(x0) ; addi x6,x5,1 → mem[1]=12, x5=12, x6=13, stall count +1.
4. x1=x2=3; beq x1,x2,+8 followed by addi x7,x0,9 → x7 stays 0, flush count +1, PC jumps by 8. Unequal operands → x7=9, no flush.
5. addi x8,x0,-16 ; srai x9,x8,2 ; addi x10,x0,1 ; sll x11,x10,x10 → x9=-4, x11=2.
6. With RISCV_PIPE_MUL_EN: mul x12,x1,x2 with x1=6, x2=-3 → x12=-18. Without it: x12 unchanged. Writes to x0 leave x0=0.
